// File: rtl/mem_ctrl.sv
// Byte-wide unified RAM controller shared by the instruction fetcher and the LSB.
// Serialises 1/2/4-byte accesses into byte transfers and assembles little-endian words.
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic        in_rollback,
  input  logic        in_fetch_req,
  input  logic [31:0] in_fetch_addr,
  output logic        out_fetch_done,
  output logic [31:0] out_fetch_inst,
  input  logic        in_ls_req,
  input  logic        in_ls_we,
  input  logic [1:0]  in_ls_len,
  input  logic [31:0] in_ls_addr,
  input  logic [31:0] in_ls_wdata,
  output logic        out_ls_done,
  output logic [31:0] out_ls_rdata,
  input  logic [7:0]  in_mem_din,
  output logic [7:0]  out_mem_dout,
  output logic [31:0] out_mem_a,
  output logic        out_mem_wr
);

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, STORE} state_t;

  state_t      state;
  logic [2:0]  step;
  logic [2:0]  len;
  logic [31:0] base;
  logic [31:0] wdata;
  logic [31:0] rbuf;
  logic        fetch_done_q;
  logic        ls_done_q;
  logic        ls_done_store;
  logic        last_ls;
  logic        mem_wr_q;

  logic [2:0]  nxt;
  logic [1:0]  bidx;
  logic [31:0] rbuf_nxt;
  logic [31:0] step_addr;
  logic [2:0]  ls_n;
  logic        fetch_ok;
  logic        ls_ok;
  logic        grant_ls;
  logic        grant_fetch;

  // step counts edges since the grant; a read byte arrives two edges after its address
  always_comb begin
    nxt       = step + 3'd1;
    bidx      = nxt[1:0] - 2'd2;
    rbuf_nxt  = rbuf;
    rbuf_nxt[{bidx, 3'b000} +: 8] = in_mem_din;
    step_addr = base + {29'd0, nxt};
    case (in_ls_len)
      2'b00:   ls_n = 3'd1;
      2'b01:   ls_n = 3'd2;
      default: ls_n = 3'd4;
    endcase
    fetch_ok    = in_fetch_req & ~fetch_done_q & ~in_rollback;
    ls_ok       = in_ls_req & ~ls_done_q & (in_ls_we | ~in_rollback);
    grant_ls    = ls_ok & (~fetch_ok | ~last_ls);
    grant_fetch = fetch_ok & ~grant_ls;
  end

  assign out_mem_wr     = mem_wr_q & ena;
  assign out_fetch_done = fetch_done_q & ~in_rollback;
  assign out_ls_done    = ls_done_q & (ls_done_store | ~in_rollback);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      step           <= '0;
      len            <= '0;
      base           <= '0;
      wdata          <= '0;
      rbuf           <= '0;
      fetch_done_q   <= 1'b0;
      ls_done_q      <= 1'b0;
      ls_done_store  <= 1'b0;
      last_ls        <= 1'b0;
      mem_wr_q       <= 1'b0;
      out_mem_a      <= '0;
      out_mem_dout   <= '0;
      out_fetch_inst <= '0;
      out_ls_rdata   <= '0;
    end else if (ena) begin
      fetch_done_q <= 1'b0;
      ls_done_q    <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_ls) begin
            base      <= in_ls_addr;
            len       <= ls_n;
            wdata     <= in_ls_wdata;
            step      <= '0;
            rbuf      <= '0;
            out_mem_a <= in_ls_addr;
            last_ls   <= 1'b1;
            if (in_ls_we) begin
              state        <= STORE;
              mem_wr_q     <= 1'b1;
              out_mem_dout <= in_ls_wdata[7:0];
            end else begin
              state <= LOAD;
            end
          end else if (grant_fetch) begin
            base      <= in_fetch_addr;
            len       <= 3'd4;
            step      <= '0;
            rbuf      <= '0;
            out_mem_a <= in_fetch_addr;
            last_ls   <= 1'b0;
            state     <= FETCH;
          end
        end
        FETCH, LOAD: begin
          if (in_rollback) begin
            state <= IDLE;
          end else begin
            step <= nxt;
            if (nxt < len) out_mem_a <= step_addr;
            if (nxt >= 3'd2) rbuf <= rbuf_nxt;
            if (nxt == len + 3'd1) begin
              state <= IDLE;
              if (state == FETCH) begin
                fetch_done_q   <= 1'b1;
                out_fetch_inst <= rbuf_nxt;
              end else begin
                ls_done_q     <= 1'b1;
                ls_done_store <= 1'b0;
                out_ls_rdata  <= rbuf_nxt;
              end
            end
          end
        end
        STORE: begin
          // stores ignore rollback: they are already committed
          step <= nxt;
          if (nxt < len) begin
            out_mem_a    <= step_addr;
            out_mem_dout <= wdata[{nxt[1:0], 3'b000} +: 8];
          end else begin
            mem_wr_q      <= 1'b0;
            ls_done_q     <= 1'b1;
            ls_done_store <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: fixed vector table, hand-built corner sequences,
// and randomized traffic checked against a byte-array memory model.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst, ena, rollback;
  logic        fetch_req, fetch_done, ls_req, ls_we, ls_done, mem_wr;
  logic [31:0] fetch_addr, fetch_inst, ls_addr, ls_wdata, ls_rdata, mem_a;
  logic [1:0]  ls_len;
  logic [7:0]  mem_din, mem_dout;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .ena(ena), .in_rollback(rollback),
    .in_fetch_req(fetch_req), .in_fetch_addr(fetch_addr),
    .out_fetch_done(fetch_done), .out_fetch_inst(fetch_inst),
    .in_ls_req(ls_req), .in_ls_we(ls_we), .in_ls_len(ls_len),
    .in_ls_addr(ls_addr), .in_ls_wdata(ls_wdata),
    .out_ls_done(ls_done), .out_ls_rdata(ls_rdata),
    .in_mem_din(mem_din), .out_mem_dout(mem_dout),
    .out_mem_a(mem_a), .out_mem_wr(mem_wr)
  );

  always #5 clk = ~clk;

  // RAM: latches address at an edge, data readable the following cycle
  logic [7:0]  ram [1024];
  logic [31:0] a_q = '0;
  logic [39:0] wq[$];
  int          wcount = 0;
  assign mem_din = ram[a_q[9:0]];

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = (i == 4) ? 8'h13 : 8'h00;
    forever begin
      @(posedge clk);
      if (ena && mem_wr) begin
        ram[mem_a[9:0]] = mem_dout;
        wq.push_back({mem_a, mem_dout});
        wcount++;
      end
      if (ena) a_q <= mem_a;
    end
  end

  logic [7:0] shadow [1024];
  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          f;
    bit          we;
    logic [1:0]  len;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic int nbytes(input bit f, input logic [1:0] len);
    if (f) return 4;
    return (len == 2'b00) ? 1 : ((len == 2'b01) ? 2 : 4);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, input int n);
    logic [31:0] r = '0;
    for (int i = 0; i < n; i++) begin
      logic [31:0] t = a + 32'(i);
      r[8*i +: 8] = shadow[t[9:0]];
    end
    return r;
  endfunction

  task automatic xact(input bit f, input bit we, input logic [1:0] len, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] exp, input int exp_lat,
                      input int stall_at, input int rb_at, input string nm);
    int n, k, act, w0;
    logic [31:0] frozen;
    logic [31:0] addrs[$];
    bit stall_bad, done_seen;
    n = nbytes(f, len);
    @(negedge clk);
    w0 = wcount;
    if (f) begin
      fetch_req = 1'b1; fetch_addr = a;
    end else begin
      ls_req = 1'b1; ls_we = we; ls_len = len; ls_addr = a; ls_wdata = wd;
    end
    @(posedge clk);
    k = 0; act = 0; stall_bad = 0; done_seen = 0;
    while (k < 40) begin
      @(negedge clk);
      if (act < n) addrs.push_back(mem_a);
      if (f ? fetch_done : ls_done) begin
        done_seen = 1;
        break;
      end
      if (k == rb_at) rollback = 1'b1;
      if (k == stall_at) begin
        frozen = mem_a;
        ena = 1'b0;
        repeat (3) begin
          @(posedge clk); k++;
          @(negedge clk);
          if (mem_wr !== 1'b0 || mem_a !== frozen) stall_bad = 1;
        end
        ena = 1'b1;
      end
      @(posedge clk); k++; act++;
    end
    rollback = 1'b0; fetch_req = 1'b0; ls_req = 1'b0;
    chk({nm, " done"}, 32'(done_seen), 32'd1);
    chk({nm, " latency"}, 32'(k), 32'(exp_lat));
    if (stall_at >= 0) chk({nm, " stall freeze"}, 32'(stall_bad), 32'd0);
    if (we && !f) begin
      chk({nm, " write count"}, 32'(wcount - w0), 32'(n));
      for (int i = 0; i < n && w0 + i < wq.size(); i++) begin
        logic [31:0] t = a + 32'(i);
        chk({nm, " write addr"}, wq[w0 + i][39:8], t);
        chk({nm, " write data"}, {24'd0, wq[w0 + i][7:0]}, {24'd0, wd[8*i +: 8]});
        shadow[t[9:0]] = wd[8*i +: 8];
      end
    end else begin
      for (int i = 0; i < n && i < addrs.size(); i++)
        chk({nm, " read addr"}, addrs[i], a + 32'(i));
      chk({nm, " data"}, f ? fetch_inst : ls_rdata, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    int bad, w0, k;
    int ev[$];
    int exp_ev[4] = '{4, 17, 22, 35};

    for (int i = 0; i < 1024; i++) shadow[i] = (i == 4) ? 8'h13 : 8'h00;
    rst = 1'b1; ena = 1'b1; rollback = 1'b0;
    fetch_req = 1'b0; fetch_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_len = '0; ls_addr = '0; ls_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    chk("reset mem_a", mem_a, 32'd0);
    chk("reset mem_dout", {24'd0, mem_dout}, 32'd0);
    chk("reset mem_wr", 32'(mem_wr), 32'd0);
    chk("reset fetch_done", 32'(fetch_done), 32'd0);
    chk("reset ls_done", 32'(ls_done), 32'd0);
    chk("reset fetch_inst", fetch_inst, 32'd0);
    chk("reset ls_rdata", ls_rdata, 32'd0);

    // {fetch, we, len, addr, wdata, expected data, expected latency}
    vecs = '{
      '{1, 0, 2'b10, 32'h0000_0004, 32'h0,         32'h0000_0013, 5},
      '{0, 1, 2'b01, 32'h0000_0100, 32'h0000_BEEF, 32'h0,         2},
      '{0, 0, 2'b00, 32'h0000_0101, 32'h0,         32'h0000_00BE, 2},
      '{0, 0, 2'b11, 32'h0000_0100, 32'h0,         32'h0000_BEEF, 5},
      '{0, 1, 2'b10, 32'h0000_0200, 32'h1122_3344, 32'h0,         4},
      '{0, 0, 2'b10, 32'h0000_0200, 32'h0,         32'h1122_3344, 5},
      '{0, 0, 2'b01, 32'h0000_0201, 32'h0,         32'h0000_2233, 3},
      '{0, 0, 2'b00, 32'h0000_0203, 32'h0,         32'h0000_0011, 2},
      '{0, 1, 2'b00, 32'h0000_0202, 32'hFFFF_FFAB, 32'h0,         1},
      '{0, 0, 2'b10, 32'h0000_0200, 32'h0,         32'h11AB_3344, 5},
      '{0, 1, 2'b10, 32'hFFFF_FFFE, 32'hCAFE_F00D, 32'h0,         4},
      '{0, 0, 2'b10, 32'hFFFF_FFFE, 32'h0,         32'hCAFE_F00D, 5},
      '{1, 0, 2'b00, 32'h0000_0000, 32'h0,         32'h0000_CAFE, 5},
      '{0, 0, 2'b01, 32'hFFFF_FFFF, 32'h0,         32'h0000_FEF0, 3}
    };
    foreach (vecs[i])
      xact(vecs[i].f, vecs[i].we, vecs[i].len, vecs[i].addr, vecs[i].wdata,
           vecs[i].exp, vecs[i].lat, -1, -1, $sformatf("vec%0d", i));

    // rollback two cycles into a word fetch
    @(negedge clk) begin fetch_req = 1'b1; fetch_addr = 32'h4; end
    @(posedge clk);
    repeat (2) begin @(negedge clk); @(posedge clk); end
    @(negedge clk);
    rollback = 1'b1; fetch_req = 1'b0; bad = 0;
    if (fetch_done !== 1'b0) bad = 1;
    @(posedge clk);
    @(negedge clk) rollback = 1'b0;
    repeat (8) begin
      if (fetch_done !== 1'b0) bad = 1;
      @(posedge clk); @(negedge clk);
    end
    chk("rollback fetch no done", 32'(bad), 32'd0);
    chk("rollback fetch inst held", fetch_inst, 32'h0000_CAFE);
    xact(0, 0, 2'b00, 32'h101, 32'h0, 32'h0000_00BE, 2, -1, -1, "after rollback");

    // rollback during a load's done cycle gates the pulse
    @(negedge clk) begin ls_req = 1'b1; ls_we = 1'b0; ls_len = 2'b00; ls_addr = 32'h203; end
    @(posedge clk); @(negedge clk); @(posedge clk); @(negedge clk);
    @(posedge clk); #1 rollback = 1'b1;
    @(negedge clk);
    chk("load done gated", 32'(ls_done), 32'd0);
    chk("load gated rdata", ls_rdata, 32'h0000_0011);
    ls_req = 1'b0;
    @(posedge clk); #1 rollback = 1'b0;

    xact(0, 1, 2'b10, 32'h300, 32'h5566_7788, 32'h0, 4, -1, 2, "store rollback");
    xact(0, 0, 2'b10, 32'h200, 32'h0, 32'h11AB_3344, 8, 2, -1, "load stall");
    xact(0, 1, 2'b10, 32'h240, 32'hA1B2_C3D4, 32'h0, 7, 1, -1, "store stall");
    xact(0, 0, 2'b10, 32'h240, 32'h0, 32'hA1B2_C3D4, 5, -1, -1, "store stall readback");

    // asynchronous reset in the middle of a word store
    @(negedge clk) begin
      ls_req = 1'b1; ls_we = 1'b1; ls_len = 2'b10; ls_addr = 32'h380; ls_wdata = 32'h9988_7766;
    end
    w0 = wcount;
    @(posedge clk); @(negedge clk); @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async rst mem_wr", 32'(mem_wr), 32'd0);
    chk("async rst mem_a", mem_a, 32'd0);
    chk("async rst mem_dout", {24'd0, mem_dout}, 32'd0);
    chk("async rst ls_done", 32'(ls_done), 32'd0);
    chk("async rst fetch_inst", fetch_inst, 32'd0);
    chk("async rst ls_rdata", ls_rdata, 32'd0);
    @(negedge clk) ls_req = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    chk("async rst write count", 32'(wcount - w0), 32'd1);
    shadow[10'h380] = 8'h66;

    // simultaneous requests after reset: LSB first, then strict alternation
    @(negedge clk) begin
      fetch_req = 1'b1; fetch_addr = 32'h4;
      ls_req = 1'b1; ls_we = 1'b0; ls_len = 2'b00; ls_addr = 32'h101;
    end
    @(posedge clk);
    k = 0;
    while (k < 30) begin
      @(negedge clk);
      if (ls_done) ev.push_back(2 * k);
      if (fetch_done) ev.push_back(2 * k + 1);
      if (ev.size() >= 4) break;
      @(posedge clk); k++;
    end
    fetch_req = 1'b0; ls_req = 1'b0;
    chk("tie event count", 32'(ev.size()), 32'd4);
    for (int i = 0; i < 4 && i < ev.size(); i++)
      chk($sformatf("tie event %0d (2*cycle+is_fetch)", i), 32'(ev[i]), 32'(exp_ev[i]));
    chk("tie fetch inst", fetch_inst, 32'h0000_0013);
    chk("tie load data", ls_rdata, 32'h0000_00BE);

    // randomized traffic against the byte-array model
    for (int t = 0; t < 40; t++) begin
      bit f, we;
      logic [1:0] len;
      logic [31:0] a, wd, exp;
      int n, lat, st;
      f   = ($urandom_range(0, 2) == 0);
      we  = f ? 1'b0 : 1'($urandom_range(0, 1));
      len = 2'($urandom_range(0, 3));
      a   = $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      wd  = $urandom;
      n   = nbytes(f, len);
      exp = model_read(a, n);
      lat = (we && !f) ? n : n + 1;
      st  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      if (st >= 0) lat += 3;
      xact(f, we, len, a, wd, exp, lat, st, -1, $sformatf("rand%0d", t));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
